// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM state encoding,
// slot/channel index helpers, frame-ring step and configuration check.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_BUSY,
    ST_DONE
  } arb_state_e;

  // Up to 4 channels -> up to 8 slots (w0..w(N-1), r0..r(N-1)).
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned CH_W   = 2;

  function automatic logic [SLOT_W-1:0] slot_add(input logic [SLOT_W-1:0] base,
                                                 input int unsigned off,
                                                 input int unsigned nslot);
    int unsigned s;
    s = (32'(base) + off) % nslot;
    return SLOT_W'(s);
  endfunction

  function automatic logic slot_is_rd(input logic [SLOT_W-1:0] slot,
                                      input int unsigned num_ch);
    return 32'(slot) >= num_ch;
  endfunction

  function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] slot,
                                              input int unsigned num_ch);
    int unsigned s;
    s = 32'(slot);
    if (s >= num_ch) s = s - num_ch;
    return CH_W'(s);
  endfunction

  function automatic int unsigned frame_inc(input int unsigned idx,
                                            input int unsigned frame_num);
    return (idx + 1 >= frame_num) ? 0 : idx + 1;
  endfunction

  function automatic bit arb_cfg_ok(input int unsigned num_ch,
                                    input int unsigned frame_num,
                                    input int unsigned frame_w);
    return (num_ch >= 1) && (num_ch <= 4) &&
           (frame_num >= 3) && (frame_num <= 4) &&
           (frame_w == $clog2(frame_num));
  endfunction

endpackage

// File: rtl/sdram_port_arb_frame_ring.sv
// Per-channel frame-buffer ring: the writer always skips the buffer the
// reader holds (or is about to take), so the two never share a buffer.
module frame_ring
  import sdram_arb_pkg::*;
#(
  parameter int unsigned FRAME_NUM = 3,
  parameter int unsigned FRAME_W   = 2
) (
  input  logic               clk_108m,
  input  logic               rst_n,
  input  logic               wr_frame_done,
  input  logic               rd_frame_start,
  output logic [FRAME_W-1:0] wr_pic,
  output logic [FRAME_W-1:0] rd_pic
);

  logic [FRAME_W-1:0] last;
  logic [FRAME_W-1:0] rd_next;
  logic [FRAME_W-1:0] wr_step;
  logic [FRAME_W-1:0] wr_next;

  always_comb begin
    rd_next = rd_frame_start ? last : rd_pic;
    wr_step = FRAME_W'(frame_inc(32'(wr_pic), FRAME_NUM));
    wr_next = (wr_step == rd_next) ? FRAME_W'(frame_inc(32'(wr_step), FRAME_NUM)) : wr_step;
  end

  always_ff @(posedge clk_108m) begin
    if (!rst_n) begin
      wr_pic <= '0;
      rd_pic <= FRAME_W'(FRAME_NUM - 1);
      last   <= FRAME_W'(FRAME_NUM - 1);
    end else begin
      rd_pic <= rd_next;
      if (wr_frame_done) begin
        last   <= wr_pic;
        wr_pic <= wr_next;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin burst arbiter multiplexing NUM_CH write and NUM_CH read clients
// onto the single write/read ports of sdram_if, plus per-channel frame rings.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned FRAME_NUM = 3,
  parameter int unsigned FRAME_W   = 2
) (
  input  logic                        clk_108m,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           wr_req,
  input  logic [NUM_CH*LEN_W-1:0]     wr_len,
  input  logic [NUM_CH*ADDR_W-1:0]    wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]    wr_data,
  output logic [NUM_CH-1:0]           wr_data_rq,
  output logic [NUM_CH-1:0]           wr_done,
  input  logic [NUM_CH-1:0]           rd_req,
  input  logic [NUM_CH*LEN_W-1:0]     rd_len,
  input  logic [NUM_CH*ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_CH-1:0]           rd_data_en,
  output logic [NUM_CH-1:0]           rd_done,
  input  logic [NUM_CH-1:0]           wr_frame_done,
  input  logic [NUM_CH-1:0]           rd_frame_start,
  output logic [NUM_CH*FRAME_W-1:0]   wr_pic,
  output logic [NUM_CH*FRAME_W-1:0]   rd_pic,
  output logic                        sdr_wr_rq,
  output logic [LEN_W-1:0]            sdr_wr_len,
  output logic [ADDR_W-1:0]           sdr_wr_addr,
  output logic [DATA_W-1:0]           sdr_wr_data,
  input  logic                        sdr_wr_data_rq,
  input  logic                        sdr_wr_end,
  output logic                        sdr_rd_rq,
  output logic [LEN_W-1:0]            sdr_rd_len,
  output logic [ADDR_W-1:0]           sdr_rd_addr,
  input  logic [DATA_W-1:0]           sdr_rd_data,
  input  logic                        sdr_rd_en,
  input  logic                        sdr_rd_end
);

  localparam int unsigned NSLOT  = 2 * NUM_CH;
  localparam int unsigned PEND_W = 1 << SLOT_W;

  if (!arb_cfg_ok(NUM_CH, FRAME_NUM, FRAME_W)) begin : g_cfg_err
    $error("sdram_port_arb: unsupported NUM_CH/FRAME_NUM/FRAME_W combination");
  end

  arb_state_e          state;
  logic [SLOT_W-1:0]   ptr;
  logic [SLOT_W-1:0]   slot_q;
  logic [CH_W-1:0]     ch_q;
  logic                rd_q;

  logic [PEND_W-1:0]   pend;
  logic [SLOT_W-1:0]   cand;
  logic [SLOT_W-1:0]   win;
  logic                win_ok;
  logic                win_rd;
  logic [CH_W-1:0]     win_ch;
  logic [LEN_W-1:0]    win_len;
  logic [ADDR_W-1:0]   win_addr;
  logic                xfer;
  logic [NUM_CH-1:0]   rd_en_route;

  // A slot whose done is showing this cycle is masked: its client only drops req next cycle.
  always_comb begin
    pend = '0;
    pend[NSLOT-1:0] = {rd_req & ~rd_done, wr_req & ~wr_done};
    win_ok = 1'b0;
    win    = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      cand = slot_add(ptr, k, NSLOT);
      if (!win_ok && pend[cand]) begin
        win_ok = 1'b1;
        win    = cand;
      end
    end
    win_rd   = slot_is_rd(win, NUM_CH);
    win_ch   = slot_ch(win, NUM_CH);
    win_len  = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_ch == CH_W'(i)) begin
        win_len  = win_rd ? rd_len[i*LEN_W +: LEN_W]    : wr_len[i*LEN_W +: LEN_W];
        win_addr = win_rd ? rd_addr[i*ADDR_W +: ADDR_W] : wr_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    xfer        = (state == ST_ISSUE) || (state == ST_BUSY);
    wr_data_rq  = '0;
    rd_en_route = '0;
    sdr_wr_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        wr_data_rq[i]  = xfer && !rd_q && sdr_wr_data_rq;
        rd_en_route[i] = xfer && rd_q && sdr_rd_en;
        if (state != ST_IDLE && !rd_q) sdr_wr_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_108m) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      slot_q      <= '0;
      ch_q        <= '0;
      rd_q        <= 1'b0;
      sdr_wr_rq   <= 1'b0;
      sdr_rd_rq   <= 1'b0;
      sdr_wr_len  <= '0;
      sdr_wr_addr <= '0;
      sdr_rd_len  <= '0;
      sdr_rd_addr <= '0;
      wr_done     <= '0;
      rd_done     <= '0;
      rd_data     <= '0;
      rd_data_en  <= '0;
    end else begin
      wr_done    <= '0;
      rd_done    <= '0;
      rd_data_en <= rd_en_route;
      if (|rd_en_route) rd_data <= sdr_rd_data;
      case (state)
        ST_IDLE: begin
          if (win_ok) begin
            slot_q <= win;
            ch_q   <= win_ch;
            rd_q   <= win_rd;
            if (win_rd) begin
              sdr_rd_len  <= win_len;
              sdr_rd_addr <= win_addr;
            end else begin
              sdr_wr_len  <= win_len;
              sdr_wr_addr <= win_addr;
            end
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (rd_q) sdr_rd_rq <= 1'b1;
          else      sdr_wr_rq <= 1'b1;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (rd_q ? sdr_rd_en : sdr_wr_data_rq) begin
            sdr_wr_rq <= 1'b0;
            sdr_rd_rq <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (rd_q ? sdr_rd_end : sdr_wr_end) state <= ST_DONE;
        end
        ST_DONE: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
              if (rd_q) rd_done[i] <= 1'b1;
              else      wr_done[i] <= 1'b1;
            end
          end
          ptr   <= slot_add(slot_q, 1, NSLOT);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ring
    frame_ring #(
      .FRAME_NUM(FRAME_NUM),
      .FRAME_W  (FRAME_W)
    ) u_ring (
      .clk_108m      (clk_108m),
      .rst_n         (rst_n),
      .wr_frame_done (wr_frame_done[g]),
      .rd_frame_start(rd_frame_start[g]),
      .wr_pic        (wr_pic[g*FRAME_W +: FRAME_W]),
      .rd_pic        (rd_pic[g*FRAME_W +: FRAME_W])
    );
  end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Parametrised successor to the fixed single-writer/single-reader SDRAM path in the video top. Multiplexes `NUM_CH` video write clients (per-channel `vin_pro`) and `NUM_CH` read clients (per-channel display/scaler readers) onto the one write port and one read port of `sdram_if`, using round-robin burst arbitration. Replaces the fixed 2-bit `wr_pic_number`/`rd_pic_number` exchange with a per-channel `FRAME_NUM`-deep frame-buffer ring that never lets a reader and its writer share a buffer. Sits between the clients and `sdram_if`, all in the `clk_108m` domain.

## Interface
Parameters:
- `NUM_CH`, 2: number of channels (1..4); gives `NUM_CH` write plus `NUM_CH` read clients.
- `DATA_W`, 16: burst data width.
- `LEN_W`, 8: burst length width (words).
- `ADDR_W`, 22: burst base address width.
- `FRAME_NUM`, 3: buffers per channel ring; 3..4.
- `FRAME_W`, 2: frame index width; must satisfy ceil(log2(`FRAME_NUM`)).

Ports. Packed client vectors are indexed by channel i.
- `clk_108m` in 1: SDRAM system clock. The single clock of the block.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_req` in `NUM_CH`: write burst request, held as a level.
- `wr_len` in `NUM_CH*LEN_W`: write burst length. Stable while `wr_req` is high.
- `wr_addr` in `NUM_CH*ADDR_W`: write burst base address. Stable while `wr_req` is high.
- `wr_data` in `NUM_CH*DATA_W`: write data.
- `wr_data_rq` out `NUM_CH`: write data request, routed from `WR_DATA_RQ_o` to the granted write client only.
- `wr_done` out `NUM_CH`: 1-cycle pulse when the channel's write burst ends.
- `rd_req`, `rd_len`, `rd_addr`: in, same shapes and rules as the write equivalents.
- `rd_data` out `DATA_W`: read data, broadcast to all read clients.
- `rd_data_en` out `NUM_CH`: `RD_DATA_EN_o`, routed to the granted read client only.
- `rd_done` out `NUM_CH`: 1-cycle pulse when the channel's read burst ends.
- `wr_frame_done` in `NUM_CH`: 1-cycle pulse; writer has completed a frame.
- `rd_frame_start` in `NUM_CH`: 1-cycle pulse; reader is starting a frame.
- `wr_pic` out `NUM_CH*FRAME_W`: per-channel frame index the writer uses.
- `rd_pic` out `NUM_CH*FRAME_W`: per-channel frame index the reader uses.
- `sdr_wr_rq`, `sdr_wr_len`, `sdr_wr_addr`, `sdr_wr_data`: out, drive `WR_RQ_i`, `WR_DATA_LEN_i`, `WR_ADDR_BASE_i`, `WR_DATA_i`.
- `sdr_wr_data_rq`, `sdr_wr_end`: in, from `WR_DATA_RQ_o` and `WR_DATA_END_o`.
- `sdr_rd_rq`, `sdr_rd_len`, `sdr_rd_addr`: out, drive `RD_RQ_i`, `RD_DATA_LEN_i`, `RD_ADDR_BASE_i`.
- `sdr_rd_data`, `sdr_rd_en`, `sdr_rd_end`: in, from `RD_DATA_o`, `RD_DATA_EN_o`, `RD_DATA_END_o`.

## Operation
- One burst is in flight at a time across all `2*NUM_CH` slots. Slot order is w0..w(N-1), then r0..r(N-1).
- Round-robin pointer: the search starts at the slot after the last granted slot. Reset value of the pointer is slot 0.
- FSM:
  - IDLE: on any pending request, latch the winning slot, its length and its address; go to SETUP.
  - SETUP: drive `sdr_*_len`/`sdr_*_addr` for one cycle before the request, as `sdram_if` requires; go to ISSUE.
  - ISSUE: hold `sdr_*_rq` high until the first `sdr_wr_data_rq` (write slot) or `sdr_rd_en` (read slot) arrives; then drop the request and go to BUSY.
  - BUSY: route data. On `sdr_*_end`, go to DONE.
  - DONE: pulse `wr_done[i]` or `rd_done[i]` and advance the pointer; go to IDLE.
- A client must keep `req` high until it sees its `done`. After the grant, a drop in `req` is ignored. The client must deassert `req` in the cycle after `done`, or it re-enters arbitration.
- `sdr_wr_data` equals `wr_data` of the granted channel. When no write slot is granted it is held at 0.
- Frame ring (per channel):
  - Reset values: `wr_pic`=0, `rd_pic`=`FRAME_NUM`-1, `last`=`FRAME_NUM`-1.
  - `wr_frame_done`: set `last`←`wr_pic`, then `wr_pic`←next index mod `FRAME_NUM` that is not equal to the post-update `rd_pic`.
  - `rd_frame_start`: set `rd_pic`←`last`, using the pre-update value of `last`.
  - Both events in the same cycle: `rd_pic` takes the old `last`, and the writer skips that value.
  - Invariant: `wr_pic`≠`rd_pic` at every cycle.

## Timing
- Reset (synchronous `rst_n`=0 at an edge): from that edge, all `sdr_*_rq`, `*_data_rq`, `*_data_en`, `*_done` are 0, and `sdr_*_len`, `sdr_*_addr`, `sdr_wr_data`, `rd_data` are 0. FSM is IDLE. A reset in the middle of a burst aborts it and produces no `done`.
- Arbitration latency: request seen in IDLE at cycle t → len/addr valid at t+1 → `sdr_*_rq` high at t+2.
- `done` pulses 2 cycles after `sdr_*_end`, via BUSY→DONE with registered outputs. The earliest next grant is in IDLE 1 cycle later.
- Data routing is combinational, so `sdram_if`'s "2 clocks ahead" timing passes through to clients. `rd_data` is registered: 1 cycle of latency, aligned with a `rd_data_en` that is also registered.
- `wr_pic`/`rd_pic` update 1 cycle after the frame pulse.

## Structure
- Package `sdram_arb_pkg` holds:
  - the FSM state enum (IDLE, SETUP, ISSUE, BUSY, DONE);
  - slot-index helpers;
  - an elaboration check for `FRAME_NUM`≥3 and for `FRAME_W`.
- Sub-module `frame_ring`: one per channel, built with a generate loop; holds `wr_pic`, `rd_pic`, `last`.

## Test plan
- `NUM_CH`=2. w0, w1 and r0 all request at once with len=8 → grants in order w0, w1, r0. Each `sdr_*_rq` rises 2 cycles after entry to IDLE. There are exactly 8 `wr_data_rq` on the granted channel only.
- Continuous requests on all four slots for 20 bursts → grant counts 5/5/5/5. No slot waits more than 3 bursts.
- Read burst len=4, `sdr_rd_data`=A0..A3 → `rd_data_en[1]`=1 for 4 cycles, and `rd_data`=A0..A3 delayed by 1 cycle; `rd_data_en[0]`=0 throughout.
- `FRAME_NUM`=3, apply `wr_frame_done`×4 with no reads → `wr_pic` sequence 0,1,0,1,0 (index 2 skipped while `rd_pic`=2). Then `rd_frame_start` → `rd_pic`=1.
- `wr_frame_done` and `rd_frame_start` in the same cycle with `wr_pic`=1, `last`=0, `rd_pic`=2 → `rd_pic`=0, `wr_pic`=2, `last`=1.
- `rst_n` low in BUSY mid-burst → all outputs 0 at the next edge, and no `done` pulse. After release, the first grant goes to slot 0.
